// File: rtl/seg_scan_driver_pkg.sv
// Shared seven-segment definitions for the multiplexed display driver.
// Holds the segment bit order, the default "0" glyph used for leading-zero
// blanking, the digit-slot index type and a one-hot anode helper.
package seg_scan_driver_pkg;

  // Segment bit positions inside a 7-bit active-high gfedcba word.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] ZERO_SEGS_DEF = 7'h3F;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    DIG_SEC_ONES = 2'd0,
    DIG_SEC_TENS = 2'd1,
    DIG_MIN_ONES = 2'd2,
    DIG_MIN_TENS = 2'd3
  } digit_e;

  function automatic logic [3:0] digit_onehot(input digit_e d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the timer controller and the scan driver.
//   sec_ones/sec_tens/min_ones/min_tens_segs : digit patterns, active-high gfedcba
//   mag_on, blink_en, lz_blank_en            : display mode controls
//   seg_n, dp_n, an_n                        : segment bus, colon, digit enables
//   frame_strobe                             : pulse when a new frame snapshot is taken
// master = controller side, slave = scan driver side.
interface seg_scan_driver_if;
  logic [6:0] sec_ones_segs;
  logic [6:0] sec_tens_segs;
  logic [6:0] min_ones_segs;
  logic [6:0] min_tens_segs;
  logic       mag_on;
  logic       blink_en;
  logic       lz_blank_en;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       frame_strobe;

  modport master (
    output sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs,
    output mag_on, blink_en, lz_blank_en,
    input  seg_n, dp_n, an_n, frame_strobe
  );

  modport slave (
    input  sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs,
    input  mag_on, blink_en, lz_blank_en,
    output seg_n, dp_n, an_n, frame_strobe
  );
endinterface

// File: rtl/seg_scan_driver_clk_divider_pulse.sv
// Free-running divider: counts 0..DIV-1 while en=1, cleared while en=0.
//   clk, rstn : clock, synchronous active-low reset
//   en        : count enable; low holds the count at 0
//   tick      : one-clock pulse on the terminal count
//   sq        : 50% square wave, high for the first DIV/2 counts of each period
module clk_divider_pulse #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick,
  output logic sq
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);
  // Starts in the high half so a freshly enabled divider shows "on" first.
  assign sq   = (cnt < HALF);
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver.
// Latches the four digit patterns once per frame, scans them onto a shared
// segment bus with dead time at the start of each digit slot, blanks a
// leading minute-tens zero, blinks the colon while cooking and can blink
// the whole display. All pins are registered.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : seg_scan_driver_if.slave (patterns/controls in, seg_n/dp_n/an_n/frame_strobe out)
//
// Digit slot sequence (idx):
//   state        | meaning
//   DIG_SEC_ONES | slot 0, seconds ones; frame snapshot taken on entry
//   DIG_SEC_TENS | slot 1, seconds tens
//   DIG_MIN_ONES | slot 2, minutes ones, carries the colon on dp
//   DIG_MIN_TENS | slot 3, minutes tens, subject to leading-zero blank
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int         CLK_HZ      = 50_000_000,
  parameter int         SCAN_HZ     = 1000,
  parameter int         BLINK_HZ    = 2,
  parameter int         DEAD_CYC    = 4,
  parameter logic [6:0] ZERO_SEGS   = ZERO_SEGS_DEF,
  parameter bit         SEG_ACT_LOW = 1'b1,
  parameter bit         AN_ACT_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  seg_scan_driver_if.slave bus
);
  localparam int SLOT_DIV  = CLK_HZ / SCAN_HZ;
  localparam int COLON_DIV = CLK_HZ;
  localparam int BLINK_DIV = CLK_HZ / BLINK_HZ;
  localparam int DW        = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC);

  generate
    if (SLOT_DIV <= DEAD_CYC + 1) begin : g_bad_cfg
      $error("seg_scan_driver: SLOT_DIV must exceed DEAD_CYC+1");
    end
  endgenerate

  logic slot_tick, colon_sq, blink_sq;
  logic slot_sq_unused, colon_tick_unused, blink_tick_unused;

  clk_divider_pulse #(.DIV(SLOT_DIV)) u_slot_div (
    .clk  (clk),
    .rstn (rstn),
    .en   (1'b1),
    .tick (slot_tick),
    .sq   (slot_sq_unused)
  );

  // Colon phase restarts whenever the magnetron starts.
  clk_divider_pulse #(.DIV(COLON_DIV)) u_colon_div (
    .clk  (clk),
    .rstn (rstn),
    .en   (bus.mag_on),
    .tick (colon_tick_unused),
    .sq   (colon_sq)
  );

  clk_divider_pulse #(.DIV(BLINK_DIV)) u_blink_div (
    .clk  (clk),
    .rstn (rstn),
    .en   (bus.blink_en),
    .tick (blink_tick_unused),
    .sq   (blink_sq)
  );

  digit_e      idx;
  logic [DW-1:0] dead_cnt;
  logic        first_pend;
  logic [6:0]  snap [NUM_DIGITS];
  logic        snap_take;
  logic        dead;

  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  logic [6:0]  seg_q;
  logic        dp_q;
  logic [3:0]  an_q;
  logic        strobe_q;

  // First slot after reset has no preceding wrap, so it snapshots on its own.
  assign snap_take = first_pend || (slot_tick && (idx == DIG_MIN_TENS));
  assign dead      = (dead_cnt < DEAD_LAST);

  always_comb begin
    an_nxt  = dead ? 4'b0000 : digit_onehot(idx);
    seg_nxt = dead ? 7'h00 : snap[idx];
    dp_nxt  = !dead && (idx == DIG_MIN_ONES) && (bus.mag_on ? colon_sq : 1'b1);
    if (bus.lz_blank_en && (idx == DIG_MIN_TENS) && (snap[DIG_MIN_TENS] == ZERO_SEGS)) begin
      an_nxt = 4'b0000;
    end
    if (bus.blink_en && !blink_sq) begin
      an_nxt = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx        <= DIG_SEC_ONES;
      dead_cnt   <= '0;
      first_pend <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
      seg_q      <= {7{SEG_ACT_LOW}};
      dp_q       <= SEG_ACT_LOW;
      an_q       <= {4{AN_ACT_LOW}};
      strobe_q   <= 1'b0;
    end else begin
      first_pend <= 1'b0;
      if (slot_tick) begin
        idx      <= digit_e'(idx + 2'd1);
        dead_cnt <= '0;
      end else if (dead_cnt != DEAD_LAST) begin
        dead_cnt <= dead_cnt + DW'(1);
      end
      if (snap_take) begin
        snap[DIG_SEC_ONES] <= bus.sec_ones_segs;
        snap[DIG_SEC_TENS] <= bus.sec_tens_segs;
        snap[DIG_MIN_ONES] <= bus.min_ones_segs;
        snap[DIG_MIN_TENS] <= bus.min_tens_segs;
      end
      // Polarity applied only here so all internal logic stays active-high.
      seg_q    <= seg_nxt ^ {7{SEG_ACT_LOW}};
      dp_q     <= dp_nxt ^ SEG_ACT_LOW;
      an_q     <= an_nxt ^ {4{AN_ACT_LOW}};
      strobe_q <= snap_take;
    end
  end

  assign bus.seg_n        = seg_q;
  assign bus.dp_n         = dp_q;
  assign bus.an_n         = an_q;
  assign bus.frame_strobe = strobe_q;
endmodule
